// File: rtl/ring_seq_checker.sv
// Ring-token order checker: locks on 3'b010, then expects 001 -> 100 -> 010 -> ...
// Optional idle timeout in TRACK is enabled by defining RSC_TIMEOUT_EN.
module ring_seq_checker #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [2:0]       in_code,
  output logic             z1,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] step_cnt,
  output logic             even,
  output logic             locked
);

  localparam logic [2:0] TOK_START = 3'b010;
  localparam logic [2:0] TOK_FIRST = 3'b001;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ONEHOT  = 2'b01;
  localparam logic [1:0] ERR_ORDER   = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  typedef enum logic [1:0] {
    ST_HUNT  = 2'd0,
    ST_TRACK = 2'd1,
    ST_FAIL  = 2'd2
  } state_e;

  // Reject nonsensical parameterisations at elaboration time.
  if (CNT_W < 1 || TIMEOUT < 1) begin : g_param_chk
    $error("ring_seq_checker: CNT_W and TIMEOUT must be >= 1");
  end

  state_e           state_q, state_d;
  logic [1:0]       err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             even_q, even_d;
  logic [2:0]       exp_q, exp_d;
  logic             z1_q, z1_d;
  logic             locked_q, locked_d;
  logic             onehot_c;

`ifdef RSC_TIMEOUT_EN
  localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic [IDLE_W-1:0] idle_inc_c;
  assign idle_inc_c = idle_q + IDLE_W'(1);
`endif

  assign onehot_c = (in_code == 3'b001) || (in_code == 3'b010) || (in_code == 3'b100);

  // Next-state, counters and registered-output decode.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    even_d  = even_q;
    exp_d   = exp_q;
`ifdef RSC_TIMEOUT_EN
    idle_d  = '0;
`endif

    case (state_q)
      ST_HUNT: begin
        if (in_valid && in_code == TOK_START) begin
          state_d = ST_TRACK;
          cnt_d   = '0;
          even_d  = 1'b1;
          exp_d   = TOK_FIRST;
        end
      end
      ST_TRACK: begin
        if (in_valid) begin
          if (!onehot_c) begin
            state_d = ST_FAIL;
            err_d   = ERR_ONEHOT;
          end else if (in_code != exp_q) begin
            state_d = ST_FAIL;
            err_d   = ERR_ORDER;
          end else begin
            cnt_d  = cnt_q + CNT_W'(1);
            even_d = ~even_q;
            case (exp_q)
              3'b001:  exp_d = 3'b100;
              3'b100:  exp_d = 3'b010;
              default: exp_d = 3'b001;
            endcase
          end
        end
`ifdef RSC_TIMEOUT_EN
        else if (idle_inc_c == IDLE_W'(TIMEOUT)) begin
          state_d = ST_FAIL;
          err_d   = ERR_TIMEOUT;
        end else begin
          idle_d = idle_inc_c;
        end
`endif
      end
      ST_FAIL: begin
        state_d = ST_FAIL;
      end
      default: begin
        state_d = ST_HUNT;
        err_d   = ERR_NONE;
      end
    endcase

    z1_d     = (state_d == ST_FAIL);
    locked_d = (state_d == ST_TRACK);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_HUNT;
      err_q    <= ERR_NONE;
      cnt_q    <= '0;
      even_q   <= 1'b1;
      exp_q    <= TOK_FIRST;
      z1_q     <= 1'b0;
      locked_q <= 1'b0;
`ifdef RSC_TIMEOUT_EN
      idle_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      even_q   <= even_d;
      exp_q    <= exp_d;
      z1_q     <= z1_d;
      locked_q <= locked_d;
`ifdef RSC_TIMEOUT_EN
      idle_q   <= idle_d;
`endif
    end
  end

  assign z1       = z1_q;
  assign err_code = err_q;
  assign step_cnt = cnt_q;
  assign even     = even_q;
  assign locked   = locked_q;

endmodule

// File: tb/tb_ring_seq_checker.sv
// Bench for ring_seq_checker: directed vector table, hand sequences, and random
// stimulus against a queue/arithmetic reference model. Two DUTs: CNT_W=8 and CNT_W=2.
module tb_ring_seq_checker;

`ifdef RSC_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int TMO = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [2:0] in_code;

  logic       z1_a, even_a, locked_a;
  logic [1:0] err_a;
  logic [7:0] cnt_a;
  logic       z1_b, even_b, locked_b;
  logic [1:0] err_b;
  logic [1:0] cnt_b;

  ring_seq_checker #(.CNT_W(8), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_code(in_code),
    .z1(z1_a), .err_code(err_a), .step_cnt(cnt_a), .even(even_a), .locked(locked_a)
  );

  ring_seq_checker #(.CNT_W(2), .TIMEOUT(TMO)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_code(in_code),
    .z1(z1_b), .err_code(err_b), .step_cnt(cnt_b), .even(even_b), .locked(locked_b)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: 0=hunt 1=track 2=fail; ring position indexes expected token.
  logic [2:0] ring [3] = '{3'b001, 3'b100, 3'b010};
  int m_state, m_err, m_cnt, m_pos, m_idle;

  task automatic model_step(input logic r, input logic v, input logic [2:0] c);
    if (!r) begin
      m_state = 0; m_err = 0; m_cnt = 0; m_pos = 0; m_idle = 0;
    end else if (m_state == 0) begin
      if (v && c == 3'b010) begin
        m_state = 1; m_cnt = 0; m_pos = 0; m_idle = 0;
      end
    end else if (m_state == 1) begin
      if (v) begin
        m_idle = 0;
        if ($countones(c) != 1) begin m_state = 2; m_err = 1; end
        else if (c != ring[m_pos]) begin m_state = 2; m_err = 2; end
        else begin m_cnt++; m_pos = (m_pos + 1) % 3; end
      end else if (TO_EN) begin
        m_idle++;
        if (m_idle >= TMO) begin m_state = 2; m_err = 3; m_idle = 0; end
      end
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [2:0] c);
    reset = r; in_valid = v; in_code = c;
    @(posedge clk);
    model_step(r, v, c);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic chk_model(input int cyc);
    string s;
    s = $sformatf("rnd%0d", cyc);
    chk({s, ".z1"},     int'(z1_a),     int'(m_state == 2));
    chk({s, ".err"},    int'(err_a),    m_err);
    chk({s, ".cnt8"},   int'(cnt_a),    m_cnt % 256);
    chk({s, ".even"},   int'(even_a),   int'(m_cnt % 2 == 0));
    chk({s, ".locked"}, int'(locked_a), int'(m_state == 1));
    chk({s, ".cnt2"},   int'(cnt_b),    m_cnt % 4);
    chk({s, ".even2"},  int'(even_b),   int'(m_cnt % 2 == 0));
    chk({s, ".z1b"},    int'(z1_b),     int'(m_state == 2));
  endtask

  typedef struct {
    logic       rst;
    logic       v;
    logic [2:0] code;
    logic       z1;
    logic [1:0] err;
    logic [7:0] cnt;
    logic       even;
    logic       lck;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic r, v;
    logic [2:0] c;

    reset = 1'b0; in_valid = 1'b0; in_code = 3'b000;

    // rst, v, code -> z1, err, cnt, even, locked (values after the edge)
    tbl.push_back('{1'b0, 1'b0, 3'b000, 1'b0, 2'd0, 8'd0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 3'b000, 1'b0, 2'd0, 8'd0, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 3'b010, 1'b0, 2'd0, 8'd0, 1'b1, 1'b1});
    tbl.push_back('{1'b1, 1'b1, 3'b001, 1'b0, 2'd0, 8'd1, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 1'b1, 3'b100, 1'b0, 2'd0, 8'd2, 1'b1, 1'b1});
    tbl.push_back('{1'b1, 1'b1, 3'b010, 1'b0, 2'd0, 8'd3, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 1'b1, 3'b001, 1'b0, 2'd0, 8'd4, 1'b1, 1'b1});
    // hunt ignores non-start tokens
    tbl.push_back('{1'b0, 1'b0, 3'b000, 1'b0, 2'd0, 8'd0, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 3'b001, 1'b0, 2'd0, 8'd0, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 3'b100, 1'b0, 2'd0, 8'd0, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 3'b111, 1'b0, 2'd0, 8'd0, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 3'b010, 1'b0, 2'd0, 8'd0, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 3'b010, 1'b0, 2'd0, 8'd0, 1'b1, 1'b1});
    // non-one-hot in track, then frozen
    tbl.push_back('{1'b1, 1'b1, 3'b110, 1'b1, 2'd1, 8'd0, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 3'b010, 1'b1, 2'd1, 8'd0, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 3'b001, 1'b1, 2'd1, 8'd0, 1'b1, 1'b0});
    // reset from fail, idle hold, then out-of-order
    tbl.push_back('{1'b0, 1'b1, 3'b010, 1'b0, 2'd0, 8'd0, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 3'b010, 1'b0, 2'd0, 8'd0, 1'b1, 1'b1});
    tbl.push_back('{1'b1, 1'b0, 3'b100, 1'b0, 2'd0, 8'd0, 1'b1, 1'b1});
    tbl.push_back('{1'b1, 1'b1, 3'b100, 1'b1, 2'd2, 8'd0, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 3'b001, 1'b1, 2'd2, 8'd0, 1'b1, 1'b0});
    // reset mid-track overrides a valid token
    tbl.push_back('{1'b0, 1'b0, 3'b000, 1'b0, 2'd0, 8'd0, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 3'b010, 1'b0, 2'd0, 8'd0, 1'b1, 1'b1});
    tbl.push_back('{1'b1, 1'b1, 3'b001, 1'b0, 2'd0, 8'd1, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 3'b100, 1'b0, 2'd0, 8'd0, 1'b1, 1'b0});

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].v, tbl[i].code);
      chk($sformatf("vec%0d.z1", i),     int'(z1_a),     int'(tbl[i].z1));
      chk($sformatf("vec%0d.err", i),    int'(err_a),    int'(tbl[i].err));
      chk($sformatf("vec%0d.cnt", i),    int'(cnt_a),    int'(tbl[i].cnt));
      chk($sformatf("vec%0d.even", i),   int'(even_a),   int'(tbl[i].even));
      chk($sformatf("vec%0d.locked", i), int'(locked_a), int'(tbl[i].lck));
    end

    // Narrow counter wrap: 5 in-order tokens after start on CNT_W=2
    drive(1'b0, 1'b0, 3'b000);
    drive(1'b1, 1'b1, 3'b010);
    drive(1'b1, 1'b1, 3'b001);
    drive(1'b1, 1'b1, 3'b100);
    drive(1'b1, 1'b1, 3'b010);
    chk("wrap.cnt_pre", int'(cnt_b), 3);
    drive(1'b1, 1'b1, 3'b001);
    chk("wrap.cnt_zero", int'(cnt_b), 0);
    chk("wrap.even_zero", int'(even_b), 1);
    drive(1'b1, 1'b1, 3'b100);
    chk("wrap.cnt", int'(cnt_b), 1);
    chk("wrap.even", int'(even_b), 0);
    chk("wrap.z1", int'(z1_b), 0);
    chk("wrap.locked", int'(locked_b), 1);
    chk("wrap.cnt8", int'(cnt_a), 5);

    // Idle timeout (or its absence) after start token
    drive(1'b0, 1'b0, 3'b000);
    drive(1'b1, 1'b1, 3'b010);
    for (int k = 1; k <= TMO; k++) begin
      drive(1'b1, 1'b0, 3'b000);
      if (k < TMO || !TO_EN) begin
        chk($sformatf("tmo%0d.z1", k), int'(z1_a), 0);
        chk($sformatf("tmo%0d.locked", k), int'(locked_a), 1);
        chk($sformatf("tmo%0d.err", k), int'(err_a), 0);
      end else begin
        chk("tmo.z1", int'(z1_a), 1);
        chk("tmo.err", int'(err_a), 3);
        chk("tmo.locked", int'(locked_a), 0);
      end
    end
    drive(1'b0, 1'b1, 3'b010);
    chk("tmo_rst.z1", int'(z1_a), 0);
    chk("tmo_rst.err", int'(err_a), 0);
    chk("tmo_rst.cnt", int'(cnt_a), 0);
    chk("tmo_rst.even", int'(even_a), 1);
    chk("tmo_rst.locked", int'(locked_a), 0);

    // Random phase against the reference model
    for (int cyc = 0; cyc < 800; cyc++) begin
      r = ($urandom_range(0, 39) != 0);
      v = ($urandom_range(0, 9) != 0);
      if (m_state == 1 && $urandom_range(0, 4) != 0)
        c = ring[m_pos];
      else if (m_state == 0 && $urandom_range(0, 1) == 0)
        c = 3'b010;
      else
        c = 3'($urandom_range(0, 7));
      drive(r, v, c);
      chk_model(cyc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
